dpram_be: RTL and testbench
===========================

Name: dpram_be

Overview:
- Next-generation true dual-port RAM for the FIFO/buffer datapaths.
- Adds per-port enables, byte-lane write enables and a configurable read-during-write mode.
- Adds an optional output pipeline stage, read-valid tracking, a post-reset memory-clear engine, and same-address write-collision arbitration with monitoring.
- Both ports are synchronous to one clock; it drops in wherever a shared-clock dual-port buffer is needed.

Parameters:
- DATA, 16, word width in bits; must be a multiple of BYTE.
- ADDR, 5, address width; depth = 2**ADDR.
- BYTE, 8, byte-lane width; lanes NB = DATA/BYTE.
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old word), 1 = write-first (merged new word).
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).
- INIT_CLEAR, 1, 1 = zero the whole array after reset before accepting accesses.

Ports:
- clK  in  1  clock, all logic on rising edge.
- rst_N  in  1  asynchronous, active-low reset.
- a_port_EN  in  1  port A access enable.
- a_port_WR  in  1  port A write (qualified by a_port_EN).
- a_port_BE  in  NB  port A byte-lane enables.
- a_port_ADDR  in  ADDR  port A address.
- a_port_data_IN  in  DATA  port A write data.
- a_port_data_OUT  out  DATA  port A read data.
- a_port_VALID  out  1  port A read data valid pulse.
- a_port_PERR  out  1  port A parity error (optional feature).
- b_port_EN, b_port_WR, b_port_BE, b_port_ADDR, b_port_data_IN, b_port_data_OUT, b_port_VALID, b_port_PERR: port B, identical to port A.
- init_BUSY  out  1  clear engine active; accesses ignored.
- collision_CLR  in  1  clears collision_FLAG and collision_COUNT.
- collision_FLAG  out  1  sticky: a write-write collision has occurred.
- collision_COUNT  out  8  saturating collision count.

Behaviour:
- Reset (rst_N low, async):
  - data_OUT, VALID, PERR, collision_FLAG and collision_COUNT go to 0.
  - init_BUSY = INIT_CLEAR.
  - Clear-engine FSM goes to CLEAR (INIT_CLEAR=1) or READY (INIT_CLEAR=0).
  - Array contents are not reset asynchronously.
- Clear-engine FSM:
  - CLEAR: writes 0 to address cnt each cycle, cnt counting 0 to 2**ADDR-1.
  - CLEAR: init_BUSY = 1; both ports' EN are ignored and VALID stays 0.
  - CLEAR exits to READY the cycle after address 2**ADDR-1 is written. Clearing takes exactly 2**ADDR cycles after rst_N deasserts.
  - READY: init_BUSY = 0, normal operation. No other transitions.
  - Reset asserted mid-clear restarts the clear from address 0.
- Access: sampled when EN=1 in READY.
  - Write (WR=1): only lanes with a BE bit set are updated.
  - Reads happen on every enabled access, writes included.
- Latency:
  - data_OUT updates 1 cycle after an enabled access (2 cycles with OUT_REG=1).
  - VALID pulses high in the same cycle data_OUT updates.
  - data_OUT holds its value when no access completes.
- Same-port read-during-write:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the post-write word, i.e. old bytes in unwritten lanes and new bytes in written lanes.
- Cross-port, same address, one port writing and the other reading: the reader always gets the pre-write word.
- Write-write collision (both writing, same address, any overlapping BE lane):
  - Overlapping lanes take port A data. Non-overlapping lanes take their own port's data.
  - collision_FLAG sets the next cycle.
  - collision_COUNT increments and saturates at 255.
  - Same-address writes with disjoint BE are not a collision.
- collision_CLR:
  - Zeroes the flag and count next cycle.
  - If asserted in the same cycle as a collision, the collision wins: flag = 1, count = 1.
- Addresses wrap naturally; any ADDR-bit value is valid.

Optional Feature:
- Macro DPRAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane, written with the lane.
  - On read, PERR is raised with the same latency/alignment as VALID if any lane's recomputed parity mismatches.
  - The clear engine writes parity 0, which is consistent with zero data.
- Not defined: no parity storage; a_port_PERR and b_port_PERR are tied to 0.

Test Plan:
- INIT_CLEAR=1, ADDR=5: release rst_N, then read addr 7 from B -> init_BUSY high for exactly 32 cycles, reads ignored meanwhile; afterwards b_port_data_OUT = 0x0000 with VALID one cycle after EN.
- A writes 0xBEEF to addr 3 with BE=2'b01, after the location held 0x1234 -> memory = 0x12EF. With RDW_MODE=0, a_port_data_OUT = 0x1234 next cycle; with RDW_MODE=1 it is 0x12EF.
- Same cycle at addr 9: A writes 0xAAAA with BE=11, B writes 0x5555 with BE=01 -> memory = 0xAAAA, collision_FLAG=1, collision_COUNT=1. Repeat with B BE=10 and A BE=01 (A 0x00AA, B 0x5500) -> memory = 0x55AA, no count change.
- Drive 300 colliding cycles -> collision_COUNT saturates at 255. collision_CLR together with a collision -> count = 1; collision_CLR alone -> count = 0, flag = 0.
- OUT_REG=1: A reads addr 4 holding 0xCAFE -> data_OUT and VALID appear 2 cycles after EN. Assert rst_N low mid-clear at address 10 -> restart, busy for a full 32 cycles again.
- DPRAM_PARITY_EN defined: force one stored parity bit to flip via hierarchical deposit, then read -> PERR=1 aligned with VALID. Without the macro, PERR stays 0.

Source files
------------

// File: rtl/dpram_be.sv
// dpram_be: shared-clock true dual-port RAM with byte-lane writes, selectable
// same-port read-during-write behaviour, optional output register, read-valid
// tracking, post-reset clear engine and write-write collision monitoring.
// Optional per-lane even parity storage/checking: define DPRAM_PARITY_EN.
module dpram_be #(
   parameter int DATA       = 16,
   parameter int ADDR       = 5,
   parameter int BYTE       = 8,
   parameter int RDW_MODE   = 0,
   parameter int OUT_REG    = 0,
   parameter int INIT_CLEAR = 1
) (
   input  logic                 clK,
   input  logic                 rst_N,
   input  logic                 a_port_EN,
   input  logic                 a_port_WR,
   input  logic [DATA/BYTE-1:0] a_port_BE,
   input  logic [ADDR-1:0]      a_port_ADDR,
   input  logic [DATA-1:0]      a_port_data_IN,
   output logic [DATA-1:0]      a_port_data_OUT,
   output logic                 a_port_VALID,
   output logic                 a_port_PERR,
   input  logic                 b_port_EN,
   input  logic                 b_port_WR,
   input  logic [DATA/BYTE-1:0] b_port_BE,
   input  logic [ADDR-1:0]      b_port_ADDR,
   input  logic [DATA-1:0]      b_port_data_IN,
   output logic [DATA-1:0]      b_port_data_OUT,
   output logic                 b_port_VALID,
   output logic                 b_port_PERR,
   output logic                 init_BUSY,
   input  logic                 collision_CLR,
   output logic                 collision_FLAG,
   output logic [7:0]           collision_COUNT
);

   localparam int NB    = DATA / BYTE;
   localparam int DEPTH = 1 << ADDR;

   typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

   localparam state_t ST_RESET = state_t'((INIT_CLEAR != 0) ? 1'b0 : 1'b1);

   state_t            state_q, state_d;
   logic [ADDR-1:0]   cnt_q, cnt_d;
   logic              clr_we;

   logic [DATA-1:0]   mem [DEPTH];

   logic              a_acc, b_acc, a_we, b_we, same_addr, collision;
   logic [NB-1:0]     a_lwe, b_lwe;
   logic [DATA-1:0]   a_old, b_old, a_wdat, b_wdat, a_rd, b_rd;
   logic              a_perr, b_perr;

   logic [DATA-1:0]   a_rd_q, a_rd_d, b_rd_q, b_rd_d;
   logic              a_vld_q, a_vld_d, b_vld_q, b_vld_d;
   logic              a_perr_q, a_perr_d, b_perr_q, b_perr_d;

   logic              coll_flag_q, coll_flag_d;
   logic [7:0]        coll_cnt_q, coll_cnt_d;

   // Clear-engine state register
   always_ff @(posedge clK or negedge rst_N) begin
      if (!rst_N) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Clear-engine next state: sweep every address once, then stay ready
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_CLEAR) begin
         cnt_d = cnt_q + ADDR'(1);
         if (cnt_q == {ADDR{1'b1}}) begin
            state_d = ST_READY;
         end
      end
   end

   // Clear-engine outputs: busy flag and the zeroing write strobe
   always_comb begin
      init_BUSY = (state_q == ST_CLEAR);
      clr_we    = (state_q == ST_CLEAR);
   end

   // Access qualification, collision detection and post-write word merge
   always_comb begin
      a_acc     = a_port_EN & ~init_BUSY;
      b_acc     = b_port_EN & ~init_BUSY;
      a_we      = a_acc & a_port_WR;
      b_we      = b_acc & b_port_WR;
      a_lwe     = {NB{a_we}} & a_port_BE;
      b_lwe     = {NB{b_we}} & b_port_BE;
      same_addr = (a_port_ADDR == b_port_ADDR);
      collision = same_addr & (|(a_lwe & b_lwe));
      a_old     = mem[a_port_ADDR];
      b_old     = mem[b_port_ADDR];
      a_wdat    = a_old;
      b_wdat    = b_old;
      // At a shared address both words become the same combined word, with
      // port A owning any lane that both ports write.
      for (int i = 0; i < NB; i++) begin
         if (a_lwe[i]) begin
            a_wdat[i*BYTE +: BYTE] = a_port_data_IN[i*BYTE +: BYTE];
         end else if (same_addr && b_lwe[i]) begin
            a_wdat[i*BYTE +: BYTE] = b_port_data_IN[i*BYTE +: BYTE];
         end
         if (same_addr && a_lwe[i]) begin
            b_wdat[i*BYTE +: BYTE] = a_port_data_IN[i*BYTE +: BYTE];
         end else if (b_lwe[i]) begin
            b_wdat[i*BYTE +: BYTE] = b_port_data_IN[i*BYTE +: BYTE];
         end
      end
      // Cross-port readers always see the pre-write word; only the port's
      // own write can be forwarded in write-first mode.
      a_rd = (RDW_MODE != 0 && a_we) ? a_wdat : a_old;
      b_rd = (RDW_MODE != 0 && b_we) ? b_wdat : b_old;
   end

   // Array write: clear sweep, else B then A so A wins an identical address
   always_ff @(posedge clK) begin
      if (clr_we) begin
         mem[cnt_q] <= '0;
      end else begin
         if (b_we) mem[b_port_ADDR] <= b_wdat;
         if (a_we) mem[a_port_ADDR] <= a_wdat;
      end
   end

`ifdef DPRAM_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH];
   logic [NB-1:0] a_fresh, b_fresh;

   function automatic logic [NB-1:0] lane_par(input logic [DATA-1:0] w);
      logic [NB-1:0] p;
      for (int i = 0; i < NB; i++) p[i] = ^w[i*BYTE +: BYTE];
      return p;
   endfunction

   // Parity check against stored bits; forwarded lanes are fresh and skipped
   always_comb begin
      a_fresh = '0;
      b_fresh = '0;
      if (RDW_MODE != 0) begin
         a_fresh = a_lwe | (same_addr ? b_lwe : '0);
         b_fresh = b_lwe | (same_addr ? a_lwe : '0);
      end
      a_perr = |((lane_par(a_old) ^ par_mem[a_port_ADDR]) & ~a_fresh);
      b_perr = |((lane_par(b_old) ^ par_mem[b_port_ADDR]) & ~b_fresh);
   end

   // Parity array write mirrors the data array write
   always_ff @(posedge clK) begin
      if (clr_we) begin
         par_mem[cnt_q] <= '0;
      end else begin
         if (b_we) par_mem[b_port_ADDR] <= lane_par(b_wdat);
         if (a_we) par_mem[a_port_ADDR] <= lane_par(a_wdat);
      end
   end
`else
   // No parity storage: error outputs are constant zero
   always_comb begin
      a_perr = 1'b0;
      b_perr = 1'b0;
   end
`endif

   // First read stage next state: capture on access, hold otherwise
   always_comb begin
      a_rd_d   = a_acc ? a_rd : a_rd_q;
      b_rd_d   = b_acc ? b_rd : b_rd_q;
      a_vld_d  = a_acc;
      b_vld_d  = b_acc;
      a_perr_d = a_acc & a_perr;
      b_perr_d = b_acc & b_perr;
   end

   // First read stage registers
   always_ff @(posedge clK or negedge rst_N) begin
      if (!rst_N) begin
         a_rd_q   <= '0;
         b_rd_q   <= '0;
         a_vld_q  <= 1'b0;
         b_vld_q  <= 1'b0;
         a_perr_q <= 1'b0;
         b_perr_q <= 1'b0;
      end else begin
         a_rd_q   <= a_rd_d;
         b_rd_q   <= b_rd_d;
         a_vld_q  <= a_vld_d;
         b_vld_q  <= b_vld_d;
         a_perr_q <= a_perr_d;
         b_perr_q <= b_perr_d;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
         logic            a_ov_q, a_ov_d, b_ov_q, b_ov_d;
         logic            a_op_q, a_op_d, b_op_q, b_op_d;

         // Output stage next state: advance only behind a valid first stage
         always_comb begin
            a_out_d = a_vld_q ? a_rd_q : a_out_q;
            b_out_d = b_vld_q ? b_rd_q : b_out_q;
            a_ov_d  = a_vld_q;
            b_ov_d  = b_vld_q;
            a_op_d  = a_perr_q;
            b_op_d  = b_perr_q;
         end

         // Output stage registers
         always_ff @(posedge clK or negedge rst_N) begin
            if (!rst_N) begin
               a_out_q <= '0;
               b_out_q <= '0;
               a_ov_q  <= 1'b0;
               b_ov_q  <= 1'b0;
               a_op_q  <= 1'b0;
               b_op_q  <= 1'b0;
            end else begin
               a_out_q <= a_out_d;
               b_out_q <= b_out_d;
               a_ov_q  <= a_ov_d;
               b_ov_q  <= b_ov_d;
               a_op_q  <= a_op_d;
               b_op_q  <= b_op_d;
            end
         end

         assign a_port_data_OUT = a_out_q;
         assign b_port_data_OUT = b_out_q;
         assign a_port_VALID    = a_ov_q;
         assign b_port_VALID    = b_ov_q;
         assign a_port_PERR     = a_op_q;
         assign b_port_PERR     = b_op_q;
      end else begin : g_no_out_reg
         assign a_port_data_OUT = a_rd_q;
         assign b_port_data_OUT = b_rd_q;
         assign a_port_VALID    = a_vld_q;
         assign b_port_VALID    = b_vld_q;
         assign a_port_PERR     = a_perr_q;
         assign b_port_PERR     = b_perr_q;
      end
   endgenerate

   // Collision monitor next state: a new collision overrides a clear
   always_comb begin
      coll_flag_d = coll_flag_q;
      coll_cnt_d  = coll_cnt_q;
      if (collision) begin
         coll_flag_d = 1'b1;
         if (collision_CLR) begin
            coll_cnt_d = 8'd1;
         end else if (coll_cnt_q != 8'hFF) begin
            coll_cnt_d = coll_cnt_q + 8'd1;
         end
      end else if (collision_CLR) begin
         coll_flag_d = 1'b0;
         coll_cnt_d  = 8'd0;
      end
   end

   // Collision monitor registers
   always_ff @(posedge clK or negedge rst_N) begin
      if (!rst_N) begin
         coll_flag_q <= 1'b0;
         coll_cnt_q  <= 8'd0;
      end else begin
         coll_flag_q <= coll_flag_d;
         coll_cnt_q  <= coll_cnt_d;
      end
   end

   assign collision_FLAG  = coll_flag_q;
   assign collision_COUNT = coll_cnt_q;

endmodule

// File: tb/tb_dpram_be.sv
// tb_dpram_be: directed bench for dpram_be. dut0 uses the default build
// (read-first, no output register); dut1 is write-first with the output
// register. Both share one stimulus set.
module tb_dpram_be;

   logic        clK;
   logic        rst_N;
   logic        a_en, a_wr, b_en, b_wr, coll_clr;
   logic [1:0]  a_be, b_be;
   logic [4:0]  a_addr, b_addr;
   logic [15:0] a_din, b_din;

   logic [15:0] d0_a_dout, d0_b_dout, d1_a_dout, d1_b_dout;
   logic        d0_a_vld, d0_b_vld, d1_a_vld, d1_b_vld;
   logic        d0_a_perr, d0_b_perr, d1_a_perr, d1_b_perr;
   logic        d0_busy, d1_busy, d0_flag, d1_flag;
   logic [7:0]  d0_cnt, d1_cnt;

   int errors = 0;
   int checks = 0;
   int nbusy;

   dpram_be #(.DATA(16), .ADDR(5), .BYTE(8), .RDW_MODE(0), .OUT_REG(0), .INIT_CLEAR(1)) dut0 (
      .clK(clK), .rst_N(rst_N),
      .a_port_EN(a_en), .a_port_WR(a_wr), .a_port_BE(a_be), .a_port_ADDR(a_addr),
      .a_port_data_IN(a_din), .a_port_data_OUT(d0_a_dout), .a_port_VALID(d0_a_vld),
      .a_port_PERR(d0_a_perr),
      .b_port_EN(b_en), .b_port_WR(b_wr), .b_port_BE(b_be), .b_port_ADDR(b_addr),
      .b_port_data_IN(b_din), .b_port_data_OUT(d0_b_dout), .b_port_VALID(d0_b_vld),
      .b_port_PERR(d0_b_perr),
      .init_BUSY(d0_busy), .collision_CLR(coll_clr), .collision_FLAG(d0_flag),
      .collision_COUNT(d0_cnt)
   );

   dpram_be #(.DATA(16), .ADDR(5), .BYTE(8), .RDW_MODE(1), .OUT_REG(1), .INIT_CLEAR(1)) dut1 (
      .clK(clK), .rst_N(rst_N),
      .a_port_EN(a_en), .a_port_WR(a_wr), .a_port_BE(a_be), .a_port_ADDR(a_addr),
      .a_port_data_IN(a_din), .a_port_data_OUT(d1_a_dout), .a_port_VALID(d1_a_vld),
      .a_port_PERR(d1_a_perr),
      .b_port_EN(b_en), .b_port_WR(b_wr), .b_port_BE(b_be), .b_port_ADDR(b_addr),
      .b_port_data_IN(b_din), .b_port_data_OUT(d1_b_dout), .b_port_VALID(d1_b_vld),
      .b_port_PERR(d1_b_perr),
      .init_BUSY(d1_busy), .collision_CLR(coll_clr), .collision_FLAG(d1_flag),
      .collision_COUNT(d1_cnt)
   );

   initial clK = 1'b0;
   always #5 clK = ~clK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clK);
      #1;
   endtask

   task automatic idle();
      a_en = 1'b0; a_wr = 1'b0;
      b_en = 1'b0; b_wr = 1'b0;
   endtask

   task automatic a_op(input logic wr, input logic [4:0] addr, input logic [15:0] din, input logic [1:0] be);
      a_en = 1'b1; a_wr = wr; a_addr = addr; a_din = din; a_be = be;
   endtask

   task automatic b_op(input logic wr, input logic [4:0] addr, input logic [15:0] din, input logic [1:0] be);
      b_en = 1'b1; b_wr = wr; b_addr = addr; b_din = din; b_be = be;
   endtask

   // Count cycles until the clear engine finishes; no read may complete meanwhile.
   task automatic count_busy(output int n);
      n = 0;
      while (d0_busy && n < 100) begin
         tick();
         n++;
         check("vld_during_clear", {d0_b_vld, d1_b_vld, d0_a_vld, d1_a_vld}, 0);
      end
      check("busy_len", n, 32);
      check("busy_dut1_done", d1_busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_N = 1'b0; coll_clr = 1'b0;
      idle();
      a_be = 2'b00; b_be = 2'b00; a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
      tick(); tick(); tick();

      // Reset state
      check("rst_busy0", d0_busy, 1);
      check("rst_busy1", d1_busy, 1);
      check("rst_dout0", {d0_a_dout, d0_b_dout}, 0);
      check("rst_vld", {d0_a_vld, d0_b_vld, d1_a_vld, d1_b_vld}, 0);
      check("rst_coll", {d0_flag, d0_cnt, d1_flag, d1_cnt}, 0);

      // Clear sequence with B holding a read of address 7
      rst_N = 1'b1;
      b_op(1'b0, 5'd7, 16'h0, 2'b00);
      count_busy(nbusy);
      tick();
      check("clr_rd_vld0", d0_b_vld, 1);
      check("clr_rd_dat0", d0_b_dout, 16'h0000);
      check("clr_rd_vld1_early", d1_b_vld, 0);
      idle();
      tick();
      check("clr_rd_vld1", d1_b_vld, 1);
      check("clr_rd_dat1", d1_b_dout, 16'h0000);
      check("clr_rd_vld0_end", d0_b_vld, 0);

      // Same-port read-during-write with a partial byte write
      a_op(1'b1, 5'd3, 16'h1234, 2'b11);
      tick();
      a_op(1'b1, 5'd3, 16'hBEEF, 2'b01);
      tick();
      check("rdw0_old", d0_a_dout, 16'h1234);
      check("rdw0_vld", d0_a_vld, 1);
      idle();
      tick();
      check("rdw1_new", d1_a_dout, 16'h12EF);
      check("rdw1_vld", d1_a_vld, 1);
      check("hold0_dat", d0_a_dout, 16'h1234);
      check("hold0_vld", d0_a_vld, 0);
      a_op(1'b0, 5'd3, 16'h0, 2'b00);
      tick();
      check("merge_rd0", d0_a_dout, 16'h12EF);
      idle();
      tick();
      check("merge_rd1", d1_a_dout, 16'h12EF);

      // Write-write collision with overlapping lanes
      a_op(1'b1, 5'd9, 16'hAAAA, 2'b11);
      b_op(1'b1, 5'd9, 16'h5555, 2'b01);
      tick();
      check("coll_flag0", d0_flag, 1);
      check("coll_cnt0", d0_cnt, 1);
      check("coll_dut1", {d1_flag, d1_cnt}, {1'b1, 8'd1});
      idle();
      tick();
      check("coll_b_wfirst1", d1_b_dout, 16'hAAAA);
      a_op(1'b0, 5'd9, 16'h0, 2'b00);
      tick();
      check("coll_mem", d0_a_dout, 16'hAAAA);

      // Same address, disjoint lanes: not a collision
      a_op(1'b1, 5'd9, 16'h00AA, 2'b01);
      b_op(1'b1, 5'd9, 16'h5500, 2'b10);
      tick();
      check("disjoint_cnt", d0_cnt, 1);
      idle();
      b_op(1'b0, 5'd9, 16'h0, 2'b00);
      tick();
      check("disjoint_mem", d0_b_dout, 16'h55AA);

      // Cross-port: B reads while A writes the same address
      a_op(1'b1, 5'd9, 16'h1111, 2'b11);
      b_op(1'b0, 5'd9, 16'h0, 2'b00);
      tick();
      check("xport_old0", d0_b_dout, 16'h55AA);
      idle();
      tick();
      check("xport_old1", d1_b_dout, 16'h55AA);
      check("xport_cnt", d0_cnt, 1);

      // Saturation after 300 further collisions
      a_op(1'b1, 5'd0, 16'h0F0F, 2'b11);
      b_op(1'b1, 5'd0, 16'hF0F0, 2'b10);
      for (int i = 0; i < 300; i++) tick();
      check("sat_cnt", d0_cnt, 255);
      check("sat_flag", d0_flag, 1);
      coll_clr = 1'b1;
      tick();
      check("clr_vs_coll_cnt", d0_cnt, 1);
      check("clr_vs_coll_flag", d0_flag, 1);
      idle();
      tick();
      check("clr_cnt", d0_cnt, 0);
      check("clr_flag", d0_flag, 0);
      coll_clr = 1'b0;
      tick();
      check("idle_cnt", d0_cnt, 0);

      // Output register latency
      a_op(1'b1, 5'd4, 16'hCAFE, 2'b11);
      tick();
      idle();
      tick(); tick();
      a_op(1'b0, 5'd4, 16'h0, 2'b00);
      tick();
      check("lat1_dat0", d0_a_dout, 16'hCAFE);
      check("lat1_vld0", d0_a_vld, 1);
      check("lat1_vld1", d1_a_vld, 0);
      check("perr_clean0", d0_a_perr, 0);
      idle();
      tick();
      check("lat2_vld1", d1_a_vld, 1);
      check("lat2_dat1", d1_a_dout, 16'hCAFE);
      check("perr_dut1", {d1_a_perr, d1_b_perr, d0_b_perr}, 0);

`ifdef DPRAM_PARITY_EN
      dut0.par_mem[4][0] = ~dut0.par_mem[4][0];
      a_op(1'b0, 5'd4, 16'h0, 2'b00);
      tick();
      check("perr_hit", {d0_a_perr, d0_a_vld}, 2'b11);
      idle();
      tick();
      check("perr_pulse", d0_a_perr, 0);
`else
      a_op(1'b0, 5'd4, 16'h0, 2'b00);
      tick();
      check("noparity_perr", {d0_a_perr, d0_a_vld}, 2'b01);
      idle();
      tick();
`endif

      // Async reset, then reset again mid-clear at address 10
      a_op(1'b1, 5'd1, 16'h1234, 2'b11);
      b_op(1'b1, 5'd1, 16'h4321, 2'b11);
      tick();
      check("pre_rst_cnt", d0_cnt, 1);
      idle();
      rst_N = 1'b0;
      #2;
      check("async_rst_cnt", {d0_flag, d0_cnt}, 0);
      check("async_rst_busy", {d0_busy, d1_busy}, 2'b11);
      tick();
      rst_N = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("midclear_busy", d0_busy, 1);
      rst_N = 1'b0;
      #2;
      tick();
      rst_N = 1'b1;
      count_busy(nbusy);
      a_op(1'b0, 5'd4, 16'h0, 2'b00);
      tick();
      check("reclear_mem", d0_a_dout, 16'h0000);
      idle();
      tick();
      check("reclear_mem1", d1_a_dout, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
